// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the raster timing generator: VGA/XGA timing sets,
// coordinate width and the registered output bundle.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   // XGA totals exceed 1024 and need a wider COORD_W before use.
   localparam int XGA_H_ACTIVE = 1024;
   localparam int XGA_H_FP     = 24;
   localparam int XGA_H_SYNC   = 136;
   localparam int XGA_H_BP     = 160;
   localparam int XGA_V_ACTIVE = 768;
   localparam int XGA_V_FP     = 3;
   localparam int XGA_V_SYNC   = 6;
   localparam int XGA_V_BP     = 29;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
   localparam int XGA_H_TOTAL = axis_total(XGA_H_ACTIVE, XGA_H_FP, XGA_H_SYNC, XGA_H_BP);
   localparam int XGA_V_TOTAL = axis_total(XGA_V_ACTIVE, XGA_V_FP, XGA_V_SYNC, XGA_V_BP);

   typedef struct packed {
      logic [COORD_W-1:0] pix_x;
      logic [COORD_W-1:0] pix_y;
      logic [COORD_W-1:0] frame_count;
      logic               video_active;
      logic               hsync;
      logic               vsync;
      logic               line_start;
      logic               frame_start;
   } vga_out_t;

   function automatic vga_out_t out_reset(input logic hpol, input logic vpol);
      vga_out_t r;
      r       = {$bits(vga_out_t){1'b0}};
      r.hsync = ~hpol;
      r.vsync = ~vpol;
      return r;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle from vga_timing_gen (master) to sync pins and background generators (slave).
interface vga_timing_if;
   logic [vga_timing_pkg::COORD_W-1:0] pix_x;
   logic [vga_timing_pkg::COORD_W-1:0] pix_y;
   logic [vga_timing_pkg::COORD_W-1:0] frame_count;
   logic                               video_active;
   logic                               hsync;
   logic                               vsync;
   logic                               line_start;
   logic                               frame_start;

   modport master (output pix_x, pix_y, frame_count, video_active, hsync, vsync, line_start, frame_start);
   modport slave  (input  pix_x, pix_y, frame_count, video_active, hsync, vsync, line_start, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter 0..TOTAL-1 with sync-window and active-region decode.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL      = 800,
   parameter int SYNC_START = 656,
   parameter int SYNC_LEN   = 96,
   parameter int ACTIVE     = 640
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [COORD_W-1:0] count,
   output logic               wrap,
   output logic               in_sync,
   output logic               in_active
);

   localparam logic [COORD_W-1:0] LAST_C  = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] SS_C    = COORD_W'(SYNC_START);
   localparam logic [COORD_W-1:0] SE_C    = COORD_W'(SYNC_START + SYNC_LEN - 1);
   localparam logic [COORD_W-1:0] ACT_C   = COORD_W'(ACTIVE);
   localparam logic [COORD_W-1:0] ONE_C   = {{(COORD_W-1){1'b0}}, 1'b1};
   localparam logic [COORD_W-1:0] ZERO_C  = {COORD_W{1'b0}};

   logic [COORD_W-1:0] count_r;

   // Axis position: advances on en and returns to zero after the last position
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= ZERO_C;
      end else if (en) begin
         if (count_r == LAST_C) begin
            count_r <= ZERO_C;
         end else begin
            count_r <= count_r + ONE_C;
         end
      end
   end

   assign count     = count_r;
   assign wrap      = en & (count_r == LAST_C);
   assign in_sync   = (count_r >= SS_C) & (count_r <= SE_C);
   assign in_active = (count_r < ACT_C);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, sync/active decode, strobes and frame counter.
// Defining VGA_PIX_DELAY_EN adds a second ce-gated output stage (latency 2 clk).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE  = VGA_H_ACTIVE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_ACTIVE  = VGA_V_ACTIVE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   vga_timing_if.master vid
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [COORD_W-1:0] ONE_C  = {{(COORD_W-1){1'b0}}, 1'b1};
   localparam logic [COORD_W-1:0] ZERO_C = {COORD_W{1'b0}};

   logic [COORD_W-1:0] h_s;
   logic [COORD_W-1:0] v_s;
   logic               h_wrap_s;
   logic               v_wrap_s;
   logic               h_sync_s;
   logic               v_sync_s;
   logic               h_act_s;
   logic               v_act_s;
   logic [COORD_W-1:0] frame_cnt_r;
   vga_out_t           dec_s;
   vga_out_t           stage_in_s;
   vga_out_t           out_r;

   vga_axis_counter #(
      .TOTAL(H_TOTAL), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .ACTIVE(H_ACTIVE)
   ) u_h_axis (
      .clk(clk), .rst(rst), .en(ce),
      .count(h_s), .wrap(h_wrap_s), .in_sync(h_sync_s), .in_active(h_act_s)
   );

   vga_axis_counter #(
      .TOTAL(V_TOTAL), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .ACTIVE(V_ACTIVE)
   ) u_v_axis (
      .clk(clk), .rst(rst), .en(h_wrap_s),
      .count(v_s), .wrap(v_wrap_s), .in_sync(v_sync_s), .in_active(v_act_s)
   );

   // Completed-frame counter, bumped as the raster leaves the last pixel of the frame
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_r <= ZERO_C;
      end else if (v_wrap_s) begin
         frame_cnt_r <= frame_cnt_r + ONE_C;
      end
   end

   // Decode of the current (h, v); frame_count already carries the new value at (0, 0)
   always_comb begin
      dec_s              = out_reset(HSYNC_POL, VSYNC_POL);
      dec_s.pix_x        = h_s;
      dec_s.pix_y        = v_s;
      dec_s.frame_count  = frame_cnt_r;
      dec_s.video_active = h_act_s & v_act_s;
      dec_s.hsync        = h_sync_s ? HSYNC_POL : ~HSYNC_POL;
      dec_s.vsync        = v_sync_s ? VSYNC_POL : ~VSYNC_POL;
      dec_s.line_start   = (h_s == ZERO_C);
      dec_s.frame_start  = (h_s == ZERO_C) & (v_s == ZERO_C);
   end

`ifdef VGA_PIX_DELAY_EN
   vga_out_t pre_r;

   // Extra stage keeps its strobes while ce is low so they reach the output on the next ce
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_r <= out_reset(HSYNC_POL, VSYNC_POL);
      end else if (ce) begin
         pre_r <= dec_s;
      end
   end

   assign stage_in_s = pre_r;
`else
   assign stage_in_s = dec_s;
`endif

   // Output register: levels hold while ce is low, strobes only follow a ce cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r <= out_reset(HSYNC_POL, VSYNC_POL);
      end else if (ce) begin
         out_r <= stage_in_s;
      end else begin
         out_r.line_start  <= 1'b0;
         out_r.frame_start <= 1'b0;
      end
   end

   assign vid.pix_x        = out_r.pix_x;
   assign vid.pix_y        = out_r.pix_y;
   assign vid.frame_count  = out_r.frame_count;
   assign vid.video_active = out_r.video_active;
   assign vid.hsync        = out_r.hsync;
   assign vid.vsync        = out_r.vsync;
   assign vid.line_start   = out_r.line_start;
   assign vid.frame_start  = out_r.frame_start;

endmodule
